// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types and helpers for the Game of Life generation engine
package life_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    COMMIT
  } state_t;

  localparam int NBR_W = 4;

  function automatic int cell_idx(input int r, input int c, input int width);
    return r * width + c;
  endfunction

endpackage

// File: rtl/life_gen_engine_if.sv
// rtl/life_gen_engine_if.sv - control, status and board-register connections of the engine
interface life_gen_engine_if #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
);
  logic                      start;
  logic                      run;
  logic [WIDTH*HEIGHT-1:0]   board_q;
  logic [WIDTH*HEIGHT-1:0]   next_d;
  logic                      board_we;
  logic                      busy;
  logic                      done;
  logic                      extinct;
  logic                      stable;
  logic [31:0]               gen_count;

  modport master (
    output start, run, board_q,
    input  next_d, board_we, busy, done, extinct, stable, gen_count
  );

  modport slave (
    input  start, run, board_q,
    output next_d, board_we, busy, done, extinct, stable, gen_count
  );
endinterface

// File: rtl/life_row_rule.sv
// rtl/life_row_rule.sv - combinational next-row computation from three neighbouring rows
module life_row_rule
  import life_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b1
) (
  input  logic [WIDTH-1:0] above,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] below,
  output logic [WIDTH-1:0] next_row
);

  for (genvar c = 0; c < WIDTH; c++) begin : g_col
    localparam int CL    = (c == 0) ? WIDTH - 1 : c - 1;
    localparam int CR    = (c == WIDTH - 1) ? 0 : c + 1;
    localparam bit HAS_L = WRAP || (c != 0);
    localparam bit HAS_R = WRAP || (c != WIDTH - 1);

    logic [2:0]       lcol;
    logic [2:0]       rcol;
    logic [NBR_W-1:0] n;

    // Edge columns without wrap see dead neighbours outside the board.
    assign lcol = HAS_L ? {above[CL], cur[CL], below[CL]} : 3'b000;
    assign rcol = HAS_R ? {above[CR], cur[CR], below[CR]} : 3'b000;

    assign n = NBR_W'(lcol[0]) + NBR_W'(lcol[1]) + NBR_W'(lcol[2])
             + NBR_W'(rcol[0]) + NBR_W'(rcol[1]) + NBR_W'(rcol[2])
             + NBR_W'(above[c]) + NBR_W'(below[c]);

    assign next_row[c] = (n == NBR_W'(3)) | (cur[c] & (n == NBR_W'(2)));
  end

endmodule

// File: rtl/life_gen_engine.sv
// rtl/life_gen_engine.sv - row-serial Game of Life step with single-cycle board commit
module life_gen_engine
  import life_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter bit WRAP   = 1'b1
) (
  input logic             clk,
  input logic             reset,
  life_gen_engine_if.slave bus
);

  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT + 1) : 1;

  state_t                  state, state_nx;
  logic [RW-1:0]           row;
  logic [WIDTH*HEIGHT-1:0] next_d_r;
  logic                    done_r, extinct_r, stable_r;
  logic [31:0]             gen_count_r;
  logic [WIDTH-1:0]        row_above, row_cur, row_below, row_next;

  // Row mux; the first and last rows borrow the opposite edge only when wrapping.
  always_comb begin
    row_cur = bus.board_q[cell_idx(int'(row), 0, WIDTH) +: WIDTH];
    if (row == '0)
      row_above = WRAP ? bus.board_q[cell_idx(HEIGHT - 1, 0, WIDTH) +: WIDTH] : '0;
    else
      row_above = bus.board_q[cell_idx(int'(row) - 1, 0, WIDTH) +: WIDTH];
    if (row == RW'(HEIGHT - 1))
      row_below = WRAP ? bus.board_q[WIDTH-1:0] : '0;
    else
      row_below = bus.board_q[cell_idx(int'(row) + 1, 0, WIDTH) +: WIDTH];
  end

  life_row_rule #(
    .WIDTH (WIDTH),
    .WRAP  (WRAP)
  ) u_rule (
    .above    (row_above),
    .cur      (row_cur),
    .below    (row_below),
    .next_row (row_next)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start || bus.run) state_nx = COMPUTE;
      COMPUTE: if (row == RW'(HEIGHT - 1)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      row         <= '0;
      next_d_r    <= '0;
      done_r      <= 1'b0;
      extinct_r   <= 1'b0;
      stable_r    <= 1'b0;
      gen_count_r <= '0;
    end else begin
      state  <= state_nx;
      done_r <= (state == COMMIT);
      case (state)
        IDLE: row <= '0;
        COMPUTE: begin
          next_d_r[cell_idx(int'(row), 0, WIDTH) +: WIDTH] <= row_next;
          row <= row + 1'b1;
        end
        COMMIT: begin
          // board_q still holds the previous generation during this cycle.
          gen_count_r <= gen_count_r + 32'd1;
          extinct_r   <= (next_d_r == '0);
          stable_r    <= (next_d_r == bus.board_q);
        end
        default: row <= '0;
      endcase
    end
  end

  assign bus.next_d    = next_d_r;
  assign bus.board_we  = (state == COMMIT);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.extinct   = extinct_r;
  assign bus.stable    = stable_r;
  assign bus.gen_count = gen_count_r;

endmodule

// File: doc/life_gen_engine.md
Name: life_gen_engine

Overview:
- Computes the next Game of Life generation from the current board and commits it to the board register in a single write-enabled cycle.
- Sits directly upstream of the board state register. It reads that register's q output as board_q and drives its d/we inputs through next_d/board_we.
- Processes one row per cycle into an internal shadow buffer, then commits the whole board at once, so board_q stays stable throughout the computation.

Parameters:
- WIDTH, 8, number of columns (>=3).
- HEIGHT, 8, number of rows (>=3).
- WRAP, 1, 1 = toroidal edges; 0 = out-of-board neighbours are dead.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request one generation step; sampled only in IDLE.
- run  input  1  when high, the engine auto-restarts after each commit (free-running).
- board_q  input  WIDTH*HEIGHT  current board; cell (r,c) is at bit r*WIDTH+c.
- next_d  output  WIDTH*HEIGHT  shadow buffer contents; drives the board register d input.
- board_we  output  1  one-cycle commit strobe to the board register we input.
- busy  output  1  high in COMPUTE and COMMIT.
- done  output  1  one-cycle pulse, the cycle after the commit.
- extinct  output  1  registered with done: the committed board is all zero.
- stable  output  1  registered with done: the committed board equals the previous board.
- gen_count  output  32  number of generations committed since reset; wraps modulo 2^32.

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset values: state=IDLE, row=0, next_d=0, board_we=0, busy=0, done=0, extinct=0, stable=0, gen_count=0.
- State machine:
  - IDLE: if start|run, go to COMPUTE with row=0. done is high in the first IDLE cycle after COMMIT only.
  - COMPUTE: each cycle writes next_d row[row] = rule(board_q rows row-1, row, row+1), then row++. When row==HEIGHT-1, go to COMMIT.
  - COMMIT: board_we=1 for exactly this cycle; next_d is held. gen_count++. extinct <= (next_d==0). stable <= (next_d==board_q). Then go to IDLE, with done=1 on the next cycle.
- Latency: start sampled at edge 0 gives busy high for cycles 1..HEIGHT+1, board_we in cycle HEIGHT+1, and done in cycle HEIGHT+2.
- Free-running: with run=1, the engine re-enters COMPUTE on the cycle done is high. The period is HEIGHT+2 cycles.
- Cell rule:
  - n = count of the 8 neighbours, 0..8, held in a 4-bit count.
  - next = (n==3) | (alive & n==2).
- Edge handling:
  - WRAP=1: neighbour indices are taken modulo WIDTH/HEIGHT.
  - WRAP=0: neighbour indices outside the board contribute 0.
- start/run while busy are ignored, with no queuing. start in the done cycle starts a new generation.
- Reset mid-COMPUTE or mid-COMMIT: return to IDLE immediately, next_d cleared, and no board_we issued after the reset edge.
- board_q must not change while busy; this is guaranteed because this block is the sole writer of the board register.
- extinct and stable hold their values until the next COMMIT.

Decomposition:
- life_pkg holds:
  - state_t enum {IDLE, COMPUTE, COMMIT};
  - NBR_W=4 constant;
  - a function for cell index r*WIDTH+c.
- Sub-module life_row_rule: combinational; takes three WIDTH-bit rows (above/cur/below) and WRAP, and outputs the WIDTH-bit next row.
- life_row_rule is instantiated once. The row mux and the wrap of row-1/row+1 live in life_gen_engine.

Test Plan:
- Blinker (5x5, WRAP=1): board_q bits {11,12,13}, pulse start. Expect board_we at cycle 6, next_d bits {7,12,17}, done at cycle 7, gen_count=1, stable=0, extinct=0.
- Block still-life (5x5): bits {6,7,11,12}. Expect next_d identical to board_q, stable=1, extinct=0.
- Lone cell (5x5): bit 12 only. Expect next_d=0, extinct=1.
- Corner wrap (5x5): bits {0,4,20}.
  - WRAP=1: expect next_d bits {0,4,20,24}.
  - WRAP=0: expect next_d=0, extinct=1.
- Handshake: start held high during busy, then run=1 for 3 generations on the blinker. Expect exactly one board_we per 7-cycle period, gen_count=3, and board oscillating vertical/horizontal/vertical.
- Reset at COMPUTE row 2: expect board_we never asserted, next_d=0, gen_count=0, busy=0 on the next cycle. A fresh start afterwards gives a correct result.
